// File: rtl/sata_oob_detect_pkg.sv
// Shared types for the SATA receive-side OOB detector: line-state encoding and
// the gap-window classification helper.
package sata_oob_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP,
    ST_ACTIVE
  } oob_state_t;

  function automatic logic in_window(input int unsigned len,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (len >= lo) && (len <= hi);
  endfunction

endpackage

// File: rtl/sata_oob_detect_sync.sv
// Two-flop synchroniser for the transceiver electrical-idle flag; both stages
// come out of reset reading idle.
module sata_oob_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) sync_q <= '1;
    else         sync_q <= {sync_q[0], i_async};
  end

  assign o_sync = sync_q[1];

endmodule

// File: rtl/sata_oob_detect.sv
// SATA OOB detector: measures burst/gap lengths on i_elecidle and pulses on
// COMINIT/COMRESET or COMWAKE. Define SATA_OOB_SYNC_EN to add a 2-flop input synchroniser.
module sata_oob_detect
  import sata_oob_detect_pkg::*;
#(
  parameter int unsigned WAKE_GAP_MIN = 6,
  parameter int unsigned WAKE_GAP_MAX = 26,
  parameter int unsigned INIT_GAP_MIN = 27,
  parameter int unsigned INIT_GAP_MAX = 78,
  parameter int unsigned BURST_MAX    = 24,
  parameter int unsigned NGAPS        = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_elecidle,
  output logic o_cominit,
  output logic o_comwake,
  output logic o_link_active
);

  localparam int unsigned LEN_MAX = (INIT_GAP_MAX > BURST_MAX) ? INIT_GAP_MAX : BURST_MAX;
  localparam int unsigned CW      = $clog2(LEN_MAX + 2);
  localparam int unsigned NW      = $clog2(NGAPS + 1);

  logic elecidle;

`ifdef SATA_OOB_SYNC_EN
  sata_oob_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_elecidle),
    .o_sync  (elecidle)
  );
`else
  assign elecidle = i_elecidle;
`endif

  oob_state_t    state;
  logic [CW-1:0] len_cnt;
  logic [CW-1:0] len_inc;
  logic [NW-1:0] wake_cnt;
  logic [NW-1:0] init_cnt;
  logic          wake_hit;
  logic          init_hit;

  // Saturating length count; the gap timeout fires before saturation matters.
  always_comb begin
    len_inc  = (len_cnt == CW'(LEN_MAX + 1)) ? len_cnt : len_cnt + CW'(1);
    wake_hit = in_window(32'(len_cnt), WAKE_GAP_MIN, WAKE_GAP_MAX);
    init_hit = in_window(32'(len_cnt), INIT_GAP_MIN, INIT_GAP_MAX);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      len_cnt       <= '0;
      wake_cnt      <= '0;
      init_cnt      <= '0;
      o_cominit     <= 1'b0;
      o_comwake     <= 1'b0;
      o_link_active <= 1'b0;
    end else begin
      o_cominit <= 1'b0;
      o_comwake <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!elecidle) begin
            state   <= ST_BURST;
            len_cnt <= CW'(1);
          end
        end
        ST_BURST: begin
          if (elecidle) begin
            state   <= ST_GAP;
            len_cnt <= CW'(1);
          end else begin
            len_cnt <= len_inc;
            if (len_inc > CW'(BURST_MAX)) begin
              state         <= ST_ACTIVE;
              wake_cnt      <= '0;
              init_cnt      <= '0;
              o_link_active <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (elecidle) begin
            len_cnt <= len_inc;
            if (len_inc > CW'(INIT_GAP_MAX)) begin
              state    <= ST_IDLE;
              wake_cnt <= '0;
              init_cnt <= '0;
            end
          end else begin
            // Burst edge closes the gap: classify its length, then restart counting.
            state    <= ST_BURST;
            len_cnt  <= CW'(1);
            if (wake_hit) begin
              init_cnt <= '0;
              if (wake_cnt == NW'(NGAPS - 1)) begin
                o_comwake <= 1'b1;
                wake_cnt  <= '0;
              end else begin
                wake_cnt <= wake_cnt + NW'(1);
              end
            end else if (init_hit) begin
              wake_cnt <= '0;
              if (init_cnt == NW'(NGAPS - 1)) begin
                o_cominit <= 1'b1;
                init_cnt  <= '0;
              end else begin
                init_cnt <= init_cnt + NW'(1);
              end
            end else begin
              wake_cnt <= '0;
              init_cnt <= '0;
            end
          end
        end
        ST_ACTIVE: begin
          if (elecidle) begin
            state         <= ST_GAP;
            len_cnt       <= CW'(1);
            o_link_active <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
